// File: rtl/iq_capture_pkg.sv
// Shared types and default sizes for the IQ capture framer.
package iq_capture_pkg;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LEN_W      = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;
endpackage

// File: rtl/iq_fwft_fifo.sv
// First-word-fall-through FIFO: head entry is always visible on dout.
// Push on a full FIFO is accepted when a pop happens in the same cycle.
module iq_fwft_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW:0]             wr_ptr, rd_ptr;
  logic                    do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Storage and pointers; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end
endmodule

// File: rtl/iq_capture_framer.sv
// Captures capture_len IQ words per start pulse and emits them as one
// AXI4-Stream frame. The input side never stalls: beats outside a capture,
// or arriving while the FIFO is full with no pop, are discarded.
module iq_capture_framer
  import iq_capture_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [LEN_W-1:0]  capture_len,
  input  logic [DATA_W-1:0] S00_axis_tdata,
  input  logic              S00_axis_tvalid,
  output logic              S00_axis_tready,
  output logic [DATA_W-1:0] m00_axis_tdata,
  output logic              m00_axis_tvalid,
  input  logic              m00_axis_tready,
  output logic              m00_axis_tlast,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
  state_t           state;
  logic [LEN_W-1:0] len, wr_cnt;
  logic [DATA_W:0]  head;
  logic             full, empty, pop, wr_en, in_last;

  assign S00_axis_tready = 1'b1;
  assign m00_axis_tvalid = !empty;
  assign m00_axis_tdata  = head[DATA_W-1:0];
  // Stored last bit is qualified by valid so an empty FIFO never shows tlast.
  assign m00_axis_tlast  = head[DATA_W] & !empty;
  assign pop             = m00_axis_tvalid & m00_axis_tready;
  assign in_last         = (wr_cnt == len - LEN_W'(1));
  assign wr_en           = (state == CAPTURE) && S00_axis_tvalid && (!full || pop);

  iq_fwft_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (wr_en),
    .din   ({in_last, S00_axis_tdata}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Frame FSM with write counter, sticky overflow and done pulse.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      len      <= '0;
      wr_cnt   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && capture_len != '0) begin
            len      <= capture_len;
            wr_cnt   <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (S00_axis_tvalid) begin
            if (wr_en) begin
              wr_cnt <= wr_cnt + LEN_W'(1);
              if (in_last) state <= DRAIN;
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (pop && m00_axis_tlast) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iq_capture_framer.sv
// Directed bench for iq_capture_framer: a per-cycle vector table for the
// basic frame plus hand-written sequences for multi-cycle corner cases.
module tb_iq_capture_framer;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start;
  logic [15:0] capture_len;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic        busy, done, overflow;

  iq_capture_framer dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .start           (start),
    .capture_len     (capture_len),
    .S00_axis_tdata  (s_tdata),
    .S00_axis_tvalid (s_tvalid),
    .S00_axis_tready (s_tready),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tready (m_tready),
    .m00_axis_tlast  (m_tlast),
    .busy            (busy),
    .done            (done),
    .overflow        (overflow)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        st;
    logic [15:0] ln;
    logic        vld;
    logic [31:0] dat;
    logic        rdy;
    logic        e_vld;
    logic [31:0] e_dat;
    logic        e_last;
    logic        e_busy;
    logic        e_done;
    logic        e_ovf;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  logic [32:0] rcv[$];
  logic [31:0] exp_q[$];
  vec_t        tbl[11];

  // Record every output handshake and done pulse, sampled mid-cycle.
  always @(negedge aclk) begin
    if (m_tvalid && m_tready) rcv.push_back({m_tlast, m_tdata});
    if (done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic [15:0] ln, input logic v,
                     input logic [31:0] d, input logic r);
    start = st; capture_len = ln; s_tvalid = v; s_tdata = d; m_tready = r;
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 64) begin
      cyc(1'b0, 16'd0, 1'b1, 32'hDEAD_BEEF, 1'b1);
      k++;
    end
    chk(nm, {31'd0, busy}, 32'd0);
    cyc(1'b0, 16'd0, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic check_frame(input string nm);
    int n;
    chk({nm, "_words"}, rcv.size(), exp_q.size());
    n = (rcv.size() < exp_q.size()) ? rcv.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({nm, "_data"}, rcv[i][31:0], exp_q[i]);
      chk({nm, "_last"}, {31'd0, rcv[i][32]}, {31'd0, (i == exp_q.size() - 1)});
    end
    chk({nm, "_done"}, done_cnt, 1);
  endtask

  function automatic vec_t mkv(logic st, logic [15:0] ln, logic vld, logic [31:0] dat,
                               logic e_vld, logic [31:0] e_dat, logic e_last,
                               logic e_busy, logic e_done);
    vec_t v;
    v = '{st, ln, vld, dat, 1'b1, e_vld, e_dat, e_last, e_busy, e_done, 1'b0};
    return v;
  endfunction

  initial begin
    logic bad;
    // Basic frame, len=8, tready=1: each word visible the cycle after its write.
    tbl[0]  = mkv(1, 16'd8, 0, 32'h0,         0, 32'h0,         0, 1, 0);
    tbl[1]  = mkv(0, 16'd0, 1, 32'h0001_0000, 1, 32'h0001_0000, 0, 1, 0);
    tbl[2]  = mkv(0, 16'd0, 1, 32'h0002_0001, 1, 32'h0002_0001, 0, 1, 0);
    tbl[3]  = mkv(0, 16'd0, 1, 32'h0003_0002, 1, 32'h0003_0002, 0, 1, 0);
    tbl[4]  = mkv(0, 16'd0, 1, 32'h0004_0003, 1, 32'h0004_0003, 0, 1, 0);
    tbl[5]  = mkv(0, 16'd0, 1, 32'h0005_0004, 1, 32'h0005_0004, 0, 1, 0);
    tbl[6]  = mkv(0, 16'd0, 1, 32'h0006_0005, 1, 32'h0006_0005, 0, 1, 0);
    tbl[7]  = mkv(0, 16'd0, 1, 32'h0007_0006, 1, 32'h0007_0006, 0, 1, 0);
    tbl[8]  = mkv(0, 16'd0, 1, 32'h0008_0007, 1, 32'h0008_0007, 1, 1, 0);
    tbl[9]  = mkv(0, 16'd0, 0, 32'h0,         0, 32'h0,         0, 0, 1);
    tbl[10] = mkv(0, 16'd0, 0, 32'h0,         0, 32'h0,         0, 0, 0);

    aresetn = 1'b0;
    start = 0; capture_len = 0; s_tvalid = 0; s_tdata = 0; m_tready = 0;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_tready", {31'd0, s_tready}, 32'd1);
    chk("rst_busy_done_ovf", {29'd0, busy, done, overflow}, 32'd0);
    aresetn = 1'b1;
    cyc(0, 16'd0, 0, 32'd0, 1);

    // Idle discard: 20 beats, no start.
    for (int i = 0; i < 20; i++) begin
      cyc(0, 16'd7, 1, $urandom, 1);
      chk("idle_tvalid", {31'd0, m_tvalid}, 32'd0);
      chk("idle_tready", {31'd0, s_tready}, 32'd1);
      chk("idle_ovf", {31'd0, overflow}, 32'd0);
    end

    // Table-driven basic frame.
    rcv.delete(); done_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].st, tbl[i].ln, tbl[i].vld, tbl[i].dat, tbl[i].rdy);
      n_vec++;
      bad = (m_tvalid !== tbl[i].e_vld) || (tbl[i].e_vld && m_tdata !== tbl[i].e_dat) ||
            (m_tlast !== tbl[i].e_last) || (busy !== tbl[i].e_busy) ||
            (done !== tbl[i].e_done) || (overflow !== tbl[i].e_ovf);
      if (bad) begin
        n_err++;
        $display("FAIL basic row %0d: got vld=%b dat=%h last=%b busy=%b done=%b ovf=%b, want vld=%b dat=%h last=%b busy=%b done=%b ovf=%b",
                 i, m_tvalid, m_tdata, m_tlast, busy, done, overflow, tbl[i].e_vld,
                 tbl[i].e_dat, tbl[i].e_last, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_ovf);
      end
    end
    chk("basic_done_cnt", done_cnt, 1);

    // Backpressure: len=6, ready low 10 cycles, beats 5 and 6 dropped.
    rcv.delete(); done_cnt = 0;
    cyc(1, 16'd6, 0, 32'd0, 0);
    for (int k = 1; k <= 6; k++) cyc(0, 16'd0, 1, 32'hA000_0000 + k, 0);
    chk("bp_ovf", {31'd0, overflow}, 32'd1);
    chk("bp_head", m_tdata, 32'hA000_0001);
    repeat (4) cyc(0, 16'd0, 0, 32'd0, 0);
    cyc(0, 16'd0, 1, 32'hA000_0007, 1);
    cyc(0, 16'd0, 1, 32'hA000_0008, 1);
    wait_idle("bp_idle");
    exp_q = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004,
              32'hA000_0007, 32'hA000_0008};
    check_frame("bp");
    chk("bp_ovf_end", {31'd0, overflow}, 32'd1);

    // Full FIFO with toggling ready: beats on pop cycles are kept.
    rcv.delete(); done_cnt = 0;
    cyc(1, 16'd8, 0, 32'd0, 0);
    for (int k = 1; k <= 4; k++) cyc(0, 16'd0, 1, 32'hC000_0000 + k, 0);
    cyc(0, 16'd0, 1, 32'hC000_0005, 1);
    cyc(0, 16'd0, 1, 32'hC000_0006, 0);
    cyc(0, 16'd0, 1, 32'hC000_0007, 1);
    cyc(0, 16'd0, 1, 32'hC000_0008, 0);
    cyc(0, 16'd0, 1, 32'hC000_0009, 1);
    chk("full_busy_mid", {31'd0, busy}, 32'd1);
    cyc(0, 16'd0, 1, 32'hC000_000A, 1);
    wait_idle("full_idle");
    exp_q = '{32'hC000_0001, 32'hC000_0002, 32'hC000_0003, 32'hC000_0004,
              32'hC000_0005, 32'hC000_0007, 32'hC000_0009, 32'hC000_000A};
    check_frame("full");

    // Ignored starts: len=0 leaves state and overflow alone; start while busy.
    cyc(1, 16'd0, 1, 32'h1234_5678, 1);
    chk("len0_busy", {31'd0, busy}, 32'd0);
    chk("len0_ovf", {31'd0, overflow}, 32'd1);
    rcv.delete(); done_cnt = 0;
    cyc(1, 16'd5, 0, 32'd0, 1);
    chk("ign_busy", {31'd0, busy}, 32'd1);
    chk("ign_ovf_clr", {31'd0, overflow}, 32'd0);
    cyc(1, 16'd3, 1, 32'hD000_0001, 1);
    for (int k = 2; k <= 5; k++) cyc(0, 16'd0, 1, 32'hD000_0000 + k, 1);
    wait_idle("ign_idle");
    exp_q = '{32'hD000_0001, 32'hD000_0002, 32'hD000_0003, 32'hD000_0004, 32'hD000_0005};
    check_frame("ign");

    // Reset mid-frame after 3 of 8 words, then a clean len=2 capture.
    cyc(1, 16'd8, 0, 32'd0, 0);
    for (int k = 1; k <= 3; k++) cyc(0, 16'd0, 1, 32'hE000_0000 + k, 0);
    #2 aresetn = 1'b0;
    #1;
    chk("mrst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("mrst_tdata", m_tdata, 32'd0);
    chk("mrst_tlast", {31'd0, m_tlast}, 32'd0);
    chk("mrst_busy_done_ovf", {29'd0, busy, done, overflow}, 32'd0);
    chk("mrst_tready", {31'd0, s_tready}, 32'd1);
    rcv.delete(); done_cnt = 0;
    @(posedge aclk);
    #1 aresetn = 1'b1;
    cyc(0, 16'd0, 0, 32'd0, 1);
    cyc(1, 16'd2, 0, 32'd0, 1);
    cyc(0, 16'd0, 1, 32'hF000_0001, 1);
    cyc(0, 16'd0, 1, 32'hF000_0002, 1);
    wait_idle("post_idle");
    exp_q = '{32'hF000_0001, 32'hF000_0002};
    check_frame("post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
